// File: rtl/turn_sequencer.sv
// Purpose: sequences one battle turn around the shared damage calculator, owns all team HP.
// Latency: move_confirm -> first HP write 1 cycle; HP visible the cycle after each HIT; SWAP steps 1 slot/cycle.
// Backpressure: pulse driven; start/move_confirm/ack outside their owning state are dropped.
module turn_sequencer #(
   parameter int TEAM_SIZE = 3,
   parameter int HP_W      = 8
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      start,
   input  logic [TEAM_SIZE*HP_W-1:0] player_maxhp,
   input  logic [TEAM_SIZE*HP_W-1:0] enemy_maxhp,
   input  logic                      move_confirm,
   input  logic                      ack,
   input  logic [HP_W-1:0]           player_spd,
   input  logic [HP_W-1:0]           enemy_spd,
   input  logic [HP_W-1:0]           dmg,
   output logic                      calc_sel,
   output logic [1:0]                my_cur,
   output logic [1:0]                opp_cur,
   output logic [HP_W-1:0]           my_hp,
   output logic [HP_W-1:0]           enemy_hp,
   output logic [2:0]                phase,
   output logic                      done,
   output logic                      result
);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      FIRST_HIT,
      FIRST_SHOW,
      SECOND_HIT,
      SECOND_SHOW,
      SWAP,
      DONE
   } state_t;

   localparam logic [1:0] LAST = 2'(TEAM_SIZE - 1);

   state_t          state;
   logic            p_first;
   logic [HP_W-1:0] p_hp [TEAM_SIZE];
   logic [HP_W-1:0] e_hp [TEAM_SIZE];
   logic [HP_W-1:0] def_hp;
   logic [HP_W-1:0] hit_hp;

   assign my_hp    = p_hp[my_cur];
   assign enemy_hp = e_hp[opp_cur];
   assign done     = (state == DONE);

   // When the player attacks the enemy defends, and vice versa; damage never wraps below 0.
   assign def_hp = calc_sel ? enemy_hp : my_hp;
   assign hit_hp = (def_hp > dmg) ? (def_hp - dmg) : '0;

   // Calculator side select: first attacker in the first half-turn, the other side in the second.
   always_comb begin
      calc_sel = 1'b0;
      case (state)
         FIRST_HIT, FIRST_SHOW:   calc_sel = p_first;
         SECOND_HIT, SECOND_SHOW: calc_sel = ~p_first;
         default:                 calc_sel = 1'b0;
      endcase
   end

   // Display code for the HP-bar/text front end.
   always_comb begin
      phase = 3'd0;
      case (state)
         IDLE:    phase = 3'd0;
         SELECT:  phase = 3'd1;
         SWAP:    phase = 3'd4;
         DONE:    phase = 3'd5;
         default: phase = calc_sel ? 3'd2 : 3'd3;
      endcase
   end

   // Turn FSM plus HP register file; only the defender's current slot is written in a HIT cycle.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= IDLE;
         p_first <= 1'b0;
         my_cur  <= 2'd0;
         opp_cur <= 2'd0;
         result  <= 1'b0;
         for (int i = 0; i < TEAM_SIZE; i++) begin
            p_hp[i] <= '0;
            e_hp[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < TEAM_SIZE; i++) begin
                     p_hp[i] <= player_maxhp[i*HP_W +: HP_W];
                     e_hp[i] <= enemy_maxhp[i*HP_W +: HP_W];
                  end
                  my_cur  <= 2'd0;
                  opp_cur <= 2'd0;
                  result  <= 1'b0;
                  state   <= SELECT;
               end
            end
            SELECT: begin
               if (move_confirm) begin
                  // Speed tie goes to the enemy.
                  p_first <= (player_spd > enemy_spd);
                  state   <= FIRST_HIT;
               end
            end
            FIRST_HIT, SECOND_HIT: begin
               if (calc_sel) e_hp[opp_cur] <= hit_hp;
               else          p_hp[my_cur]  <= hit_hp;
               state <= (state == FIRST_HIT) ? FIRST_SHOW : SECOND_SHOW;
            end
            FIRST_SHOW: begin
               // A fainted defender loses its counter-attack.
               if (ack) state <= (def_hp == '0) ? SWAP : SECOND_HIT;
            end
            SECOND_SHOW: begin
               if (ack) state <= SWAP;
            end
            SWAP: begin
               if (my_hp == '0 && my_cur == LAST) begin
                  result <= 1'b0;
                  state  <= DONE;
               end else if (enemy_hp == '0 && opp_cur == LAST) begin
                  result <= 1'b1;
                  state  <= DONE;
               end else if (my_hp == '0) begin
                  my_cur <= my_cur + 2'd1;
               end else if (enemy_hp == '0) begin
                  opp_cur <= opp_cur + 2'd1;
               end else begin
                  state <= SELECT;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Purpose: self-checking bench for turn_sequencer against a turn-level battle model.
// Latency: inputs driven and outputs sampled on the falling edge, one DUT cycle per tick.
// Backpressure: every wait is bounded; a global watchdog ends a stuck run.
module tb_turn_sequencer;
   localparam int TS = 3;
   localparam int W  = 8;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            start;
   logic [TS*W-1:0] player_maxhp;
   logic [TS*W-1:0] enemy_maxhp;
   logic            move_confirm;
   logic            ack;
   logic [W-1:0]    player_spd;
   logic [W-1:0]    enemy_spd;
   logic [W-1:0]    dmg;
   logic            calc_sel;
   logic [1:0]      my_cur;
   logic [1:0]      opp_cur;
   logic [W-1:0]    my_hp;
   logic [W-1:0]    enemy_hp;
   logic [2:0]      phase;
   logic            done;
   logic            result;

   turn_sequencer #(.TEAM_SIZE(TS), .HP_W(W)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .start        (start),
      .player_maxhp (player_maxhp),
      .enemy_maxhp  (enemy_maxhp),
      .move_confirm (move_confirm),
      .ack          (ack),
      .player_spd   (player_spd),
      .enemy_spd    (enemy_spd),
      .dmg          (dmg),
      .calc_sel     (calc_sel),
      .my_cur       (my_cur),
      .opp_cur      (opp_cur),
      .my_hp        (my_hp),
      .enemy_hp     (enemy_hp),
      .phase        (phase),
      .done         (done),
      .result       (result)
   );

   always #5 Clk = ~Clk;

   // Battle model: HP per slot, current slots, last result, battle-over flag.
   int php [TS];
   int ehp [TS];
   int mc;
   int oc;
   int mres;
   bit over;

   int n_cmp = 0;
   int n_err = 0;

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_cmp++;
      if (obs !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_sub(input int h, input int d);
      return (h > d) ? h - d : 0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < TS; i++) begin
         php[i] = 0;
         ehp[i] = 0;
      end
      mc   = 0;
      oc   = 0;
      mres = 0;
   endtask

   task automatic check_hp(input string tag);
      check({tag, "_my_cur"},   32'(my_cur),   mc);
      check({tag, "_opp_cur"},  32'(opp_cur),  oc);
      check({tag, "_my_hp"},    32'(my_hp),    php[mc]);
      check({tag, "_enemy_hp"}, 32'(enemy_hp), ehp[oc]);
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_phase"},    32'(phase),    0);
      check({tag, "_done"},     32'(done),     0);
      check({tag, "_calc_sel"}, 32'(calc_sel), 0);
      check({tag, "_result"},   32'(result),   0);
      check_hp(tag);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
      model_clear();
   endtask

   task automatic start_battle(input logic [TS*W-1:0] pm, input logic [TS*W-1:0] em);
      player_maxhp = pm;
      enemy_maxhp  = em;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < TS; i++) begin
         php[i] = int'(pm[i*W +: W]);
         ehp[i] = int'(em[i*W +: W]);
      end
      mc   = 0;
      oc   = 0;
      mres = 0;
      over = 1'b0;
      check("start_phase",  32'(phase),  1);
      check("start_result", 32'(result), 0);
      check_hp("start");
   endtask

   // One full turn from SELECT; dp/de are the calculator outputs for player/enemy attacks.
   task automatic do_turn(input int ps, input int es, input int dp, input int de, input bit abort);
      bit pf, drop, fainted, stop, fin, win;
      int adv, n;
      pf = (ps > es);

      if ($urandom_range(0, 3) == 0) begin
         ack = 1'b1;
         tick();
         ack = 1'b0;
         check("sel_ack_phase", 32'(phase), 1);
      end

      player_spd   = W'(ps);
      enemy_spd    = W'(es);
      move_confirm = 1'b1;
      tick();
      move_confirm = 1'b0;

      // First half-turn
      check("hit1_calc_sel", 32'(calc_sel), int'(pf));
      check("hit1_phase",    32'(phase),    pf ? 2 : 3);
      dmg  = W'(pf ? dp : de);
      drop = ($urandom_range(0, 3) == 0);
      ack  = drop;
      tick();
      ack = 1'b0;
      dmg = '0;
      if (pf) ehp[oc] = sat_sub(ehp[oc], dp);
      else    php[mc] = sat_sub(php[mc], de);
      check("show1_phase", 32'(phase), pf ? 2 : 3);
      check_hp("show1");

      if (drop || $urandom_range(0, 2) == 0) begin
         start        = 1'b1;
         move_confirm = 1'b1;
         player_maxhp = '1;
         tick();
         start        = 1'b0;
         move_confirm = 1'b0;
         check("show1_hold_phase", 32'(phase), pf ? 2 : 3);
         check_hp("show1_hold");
      end

      fainted = pf ? (ehp[oc] == 0) : (php[mc] == 0);
      ack = 1'b1;
      tick();
      ack = 1'b0;

      // Second half-turn only if the first defender survived
      if (!fainted) begin
         check("hit2_calc_sel", 32'(calc_sel), int'(!pf));
         check("hit2_phase",    32'(phase),    pf ? 3 : 2);
         dmg = W'(pf ? de : dp);
         tick();
         dmg = '0;
         if (pf) php[mc] = sat_sub(php[mc], de);
         else    ehp[oc] = sat_sub(ehp[oc], dp);
         check("show2_phase", 32'(phase), pf ? 3 : 2);
         check_hp("show2");
         if (abort) begin
            Reset_n = 1'b0;
            tick();
            Reset_n = 1'b1;
            model_clear();
            check_idle_reset("abort");
            over = 1'b1;
            return;
         end
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end

      // Expected swap outcome from the faint/advance rules
      adv  = 0;
      stop = 1'b0;
      fin  = 1'b0;
      win  = 1'b0;
      while (!stop) begin
         if (php[mc] == 0 && mc == TS - 1) begin
            fin = 1'b1; win = 1'b0; stop = 1'b1;
         end else if (ehp[oc] == 0 && oc == TS - 1) begin
            fin = 1'b1; win = 1'b1; stop = 1'b1;
         end else if (php[mc] == 0) begin
            mc++; adv++;
         end else if (ehp[oc] == 0) begin
            oc++; adv++;
         end else begin
            stop = 1'b1;
         end
      end

      n = 0;
      while (phase == 3'd4 && n < 20) begin
         n++;
         tick();
      end
      check("swap_cycles", 32'(n), adv + 1);

      if (fin) begin
         mres = int'(win);
         check("done_pulse",  32'(done),   1);
         check("done_phase",  32'(phase),  5);
         check("done_result", 32'(result), mres);
         tick();
         check("idle_phase",  32'(phase),  0);
         check("idle_done",   32'(done),   0);
         check("idle_result", 32'(result), mres);
         over = 1'b1;
      end else begin
         check("next_sel_phase", 32'(phase), 1);
         check("next_sel_done",  32'(done),  0);
         check_hp("next_sel");
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TS*W-1:0] pm, em;
      int v, t;

      Reset_n      = 1'b0;
      start        = 1'b0;
      move_confirm = 1'b0;
      ack          = 1'b0;
      player_maxhp = '0;
      enemy_maxhp  = '0;
      player_spd   = '0;
      enemy_spd    = '0;
      dmg          = '0;
      over         = 1'b0;

      // Reset and idle
      do_reset();
      check_idle_reset("reset");

      // Player faster, then speed tie with saturating damage
      start_battle({8'd30, 8'd30, 8'd30}, {8'd20, 8'd20, 8'd20});
      do_turn(50, 40, 5, 5, 1'b0);
      do_turn(40, 40, 200, 200, 1'b0);

      // Win path with an empty enemy slot skipped
      do_reset();
      start_battle({8'd30, 8'd30, 8'd30}, {8'd5, 8'd0, 8'd5});
      do_turn(50, 40, 10, 10, 1'b0);
      do_turn(50, 40, 10, 10, 1'b0);
      check("win_over", 32'(over), 1);

      // Lose path straight from IDLE
      start_battle({8'd1, 8'd1, 8'd1}, {8'd20, 8'd20, 8'd20});
      for (int k = 0; k < 3; k++) do_turn(40, 50, 1, 1, 1'b0);
      check("lose_over", 32'(over), 1);
      tick();
      check("lose_idle_result", 32'(result), 0);

      // Reset in SECOND_SHOW
      start_battle({8'd30, 8'd30, 8'd30}, {8'd20, 8'd20, 8'd20});
      do_turn(50, 40, 5, 5, 1'b1);

      // Randomized battles
      for (int b = 0; b < 25; b++) begin
         for (int s = 0; s < TS; s++) begin
            v = (s == 0 || $urandom_range(0, 4) != 0) ? int'($urandom_range(1, 40)) : 0;
            pm[s*W +: W] = W'(v);
            v = (s == 0 || $urandom_range(0, 4) != 0) ? int'($urandom_range(1, 40)) : 0;
            em[s*W +: W] = W'(v);
         end
         start_battle(pm, em);
         t = 0;
         while (!over && t < 100) begin
            do_turn(int'($urandom_range(0, 5)) * 10, int'($urandom_range(0, 5)) * 10,
                    int'($urandom_range(1, 25)), int'($urandom_range(1, 25)),
                    ($urandom_range(0, 29) == 0));
            t++;
         end
         check("rand_battle_ends", 32'(over), 1);
         if (!over) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Sequences one battle turn at a time around the shared stats/damage-calculation datapath. It latches both teams' starting HP, picks attack order from the two speeds, and time-shares the single damage calculator between attacker sides. It applies saturating HP updates, advances fainted Pokemon, and reports win/lose. It sits between the keyboard/menu logic (move confirm, ENTER acknowledge) and the HP-bar/text display.

Parameters:
TEAM_SIZE, 3, Pokemon per side; slot indices run 0..TEAM_SIZE-1.
HP_W, 8, HP and damage width in bits.

Ports:
Clk  input  1  system clock
Reset_n  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse; begins a battle and latches max HP
player_maxhp  input  TEAM_SIZE*HP_W  starting HP per player slot; slot i at bits [i*HP_W +: HP_W]
enemy_maxhp  input  TEAM_SIZE*HP_W  starting HP per enemy slot; same packing
move_confirm  input  1  one-cycle pulse; player committed a move
ack  input  1  one-cycle pulse; text box advanced (ENTER edge)
player_spd  input  HP_W  speed of the current player Pokemon
enemy_spd  input  HP_W  speed of the current enemy Pokemon
dmg  input  HP_W  damage from the calculator for the side chosen by calc_sel
calc_sel  output  1  1 = player attacking, 0 = enemy attacking; drives the calculator's is_player input
my_cur  output  2  current player slot
opp_cur  output  2  current enemy slot
my_hp  output  HP_W  HP of the current player slot
enemy_hp  output  HP_W  HP of the current enemy slot
phase  output  3  display code: 0 idle, 1 select, 2 player-attack text, 3 enemy-attack text, 4 swap, 5 done
done  output  1  one-cycle pulse at battle end
result  output  1  1 = win, 0 = lose; valid from done and held until the next start

Behaviour:
- Reset (Reset_n=0 at a clock edge) applies regardless of state, including mid-turn:
  - state IDLE; all HP registers 0; my_cur=0, opp_cur=0.
  - calc_sel=0, phase=0, done=0, result=0.
  - Reset has priority over every other input in the same cycle.
- States: IDLE, SELECT, FIRST_HIT, FIRST_SHOW, SECOND_HIT, SECOND_SHOW, SWAP, DONE.
- IDLE: on start, load all 2*TEAM_SIZE HP registers from the maxhp inputs, clear my_cur/opp_cur to 0, clear result, go to SELECT. Otherwise start is ignored in every state.
- SELECT: on move_confirm, register p_first = (player_spd > enemy_spd); a tie means the enemy moves first. Go to FIRST_HIT. move_confirm is ignored in all other states.
- calc_sel is combinational from state:
  - FIRST_HIT/FIRST_SHOW: calc_sel = p_first.
  - SECOND_HIT/SECOND_SHOW: calc_sel = ~p_first.
  - otherwise: 0.
- FIRST_HIT (exactly 1 cycle): sample dmg and apply it to the defender's current slot with saturating subtraction: new = (hp > dmg) ? hp - dmg : 0. Go to FIRST_SHOW.
- FIRST_SHOW: wait for ack.
  - If the defender's HP is 0, go to SWAP (a fainted Pokemon does not attack).
  - Else go to SECOND_HIT.
- SECOND_HIT: same as FIRST_HIT with roles swapped; go to SECOND_SHOW. SECOND_SHOW: on ack, go to SWAP.
- phase in the HIT/SHOW states: 2 if calc_sel=1, else 3.
- ack is ignored outside the SHOW states; a pulse landing in a HIT cycle is dropped.
- SWAP, evaluated each cycle in this priority order:
  1. Current player HP 0 and my_cur = TEAM_SIZE-1: set result=0, go to DONE.
  2. Current enemy HP 0 and opp_cur = TEAM_SIZE-1: set result=1, go to DONE.
  3. Current player HP 0: my_cur += 1, stay in SWAP.
  4. Current enemy HP 0: opp_cur += 1, stay in SWAP.
  5. Otherwise go to SELECT.
- SWAP advances at most one slot per side per cycle, so zero-HP slots (maxhp entries of 0) are skipped one cycle each. Slot indices never wrap.
- DONE: done=1 for one cycle, phase=5, then IDLE. result holds until the next start.
- my_hp and enemy_hp are combinational reads of HP[my_cur] and HP[opp_cur]. HP writes become visible the cycle after the HIT state.
- Latency: move_confirm to first HP update is 1 cycle (SELECT→FIRST_HIT edge, write at end of FIRST_HIT).
- Only the defender's current slot is ever written during battle. HP never underflows.

Test Plan:
- Reset/idle: Reset_n=0 for 2 cycles, then start with player {30,30,30}, enemy {20,20,20} → all outputs 0 after reset; after start: phase=1, my_hp=30, enemy_hp=20, slots 0/0.
- Player faster, no faint: player_spd=50, enemy_spd=40, dmg=5, move_confirm, then ack ×2 →
  - FIRST_HIT has calc_sel=1, after which enemy_hp=15.
  - SECOND_HIT has calc_sel=0, after which my_hp=25.
  - Returns to SELECT.
- Speed tie plus saturation: spd 40/40, dmg=200 → enemy attacks first, my_hp=0, second attack skipped. After ack: SWAP sets my_cur=1, my_hp=30, then SELECT.
- Win path: enemy {5,0,5}, player faster, dmg=10 →
  - Turn 1 faints enemy slot 0; SWAP steps opp_cur 1 then 2 (two cycles, slot 1 skipped).
  - Next turn faints slot 2; done pulses for 1 cycle with result=1, then IDLE.
- Lose path: player {1,1,1}, enemy faster, dmg=1 → three turns, with my_cur advancing 0→1→2. done with result=0; result stays 0 in IDLE.
- Ignored/abort inputs:
  - ack during SELECT: no effect.
  - move_confirm and start during FIRST_SHOW: no effect.
  - Reset_n=0 asserted in SECOND_SHOW: next cycle IDLE, all HP 0, done=0.
